// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 width codes, the captured request record and the accept-time fault check.
package lsu_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Any fault is resolved at accept so a faulting request never touches memory.
  function automatic logic lsu_fault(input logic        write,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr,
                                     input logic [31:0] depth);
    logic misal, bad_f3, oor;
    misal  = ((funct3[1:0] == 2'b01) && addr[0]) ||
             ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    bad_f3 = write ? (funct3 > 3'b010)
                   : ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    oor    = ({2'b00, addr[31:2]} >= depth);
    return misal || bad_f3 || oor;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/half lane logic: load extraction with sign/zero extension
// and the merge of a narrow store into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] bmask, hmask;

  always_comb begin
    sel_b = word[{byte_off, 3'b000} +: 8];
    sel_h = byte_off[1] ? word[31:16] : word[15:0];
    bmask = 32'h0000_00FF << {byte_off, 3'b000};
    hmask = 32'h0000_FFFF << {byte_off[1], 4'b0000};

    load_data = '0;
    case (funct3)
      LB:      load_data = {{24{sel_b[7]}}, sel_b};
      LH:      load_data = {{16{sel_h[15]}}, sel_h};
      LW:      load_data = word;
      LBU:     load_data = {24'h0, sel_b};
      LHU:     load_data = {16'h0, sel_h};
      default: load_data = '0;
    endcase

    // Replicated store data lines up with every lane; the mask picks one.
    store_word = wdata;
    case (funct3)
      SB:      store_word = (word & ~bmask) | ({4{wdata[7:0]}} & bmask);
      SH:      store_word = (word & ~hmask) | ({2{wdata[15:0]}} & hmask);
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory.
// Narrow stores are done as read-modify-write through lsu_align.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  logic        fault_q;
  logic [31:0] rdata_q, wword_q;
  logic [31:0] load_data, store_word;
  logic        accept, acc_fault;

  assign accept    = req_valid && (state == ST_IDLE);
  assign acc_fault = lsu_fault(req_write, req_funct3, req_addr, 32'(DEPTH_WORDS));

  lsu_align u_align (
    .funct3     (req_q.funct3),
    .byte_off   (req_q.addr[1:0]),
    .word       (mem_rdata),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (acc_fault)                            state_nxt = ST_RESP;
          else if (req_write && req_funct3 == SW)   state_nxt = ST_WRITE;
          else                                      state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = req_q.write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE:  req_ready = 1'b1;
      ST_READ: begin
        mem_read = 1'b1;
        mem_addr = {2'b00, req_q.addr[31:2]};
      end
      ST_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = {2'b00, req_q.addr[31:2]};
        mem_wdata = wword_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_fault = fault_q;
      end
      default: ;
    endcase
  end

  // wword_q is preloaded with the store data so SW skips the read phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      wword_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q   <= '{write: req_write, funct3: req_funct3,
                         addr: req_addr, wdata: req_wdata};
            fault_q <= acc_fault;
            rdata_q <= '0;
            wword_q <= req_wdata;
          end
        end
        ST_READ: begin
          if (req_q.write) wword_q <= store_word;
          else             rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, default 64, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request this cycle; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-012 resp_fault  output  1  qualified by resp_valid; misaligned, illegal funct3 or out-of-range access.
REQ-013 mem_read  output  1  word read enable to data memory.
REQ-014 mem_write  output  1  word write enable; memory writes on the rising edge while high.
REQ-015 mem_addr  output  32  word index (req_addr[31:2]).
REQ-016 mem_wdata  output  32  full word to write.
REQ-017 mem_rdata  input  32  word read data, combinational from mem_addr while mem_read is high.

Function
REQ-018 FSM states: IDLE, READ, WRITE, RESP. A request is accepted on the edge where req_valid and req_ready are both high; address, funct3, wdata and write are captured.
REQ-019 Fault on accept: LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 > 010; addr[31:2] >= DEPTH_WORDS. A fault goes IDLE->RESP with resp_fault=1 and no mem_read or mem_write ever asserted.
REQ-020 Load: IDLE->READ->RESP. READ asserts mem_read, samples mem_rdata, and selects the byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. resp_valid is high 2 cycles after accept.
REQ-021 SW: IDLE->WRITE->RESP. WRITE asserts mem_write for exactly 1 cycle with mem_wdata=req_wdata. resp_valid is high 2 cycles after accept.
REQ-022 SB/SH (read-modify-write): IDLE->READ->WRITE->RESP. READ captures the word; WRITE writes the word with only the addressed byte or half replaced by the low bits of req_wdata. resp_valid is high 3 cycles after accept.
REQ-023 RESP lasts exactly 1 cycle, then the FSM returns to IDLE. A new request can be accepted in the cycle after RESP.
REQ-024 A req_valid held while busy is ignored until req_ready=1; inputs may change freely while busy.
REQ-025 mem_read and mem_write are never high in the same cycle and are 0 outside READ and WRITE; mem_addr and mem_wdata are 0 when neither is asserted.
REQ-026 resp_rdata and resp_fault are 0 whenever resp_valid=0.

Reset
REQ-027 reset low asynchronously forces IDLE and clears all captured registers. Output values while in reset: req_ready=1; resp_valid, resp_rdata, resp_fault, mem_read, mem_write, mem_addr and mem_wdata all 0.
REQ-028 Reset asserted mid-operation (READ or WRITE) abandons the access: no further mem_write and no resp_valid for that request.

Structure
REQ-029 Package lsu_pkg holds: the state enum; funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW); default DEPTH_WORDS.
REQ-030 Combinational sub-module lsu_align performs load extraction/extension and store byte/half merge; the FSM and capture registers stay in load_store_unit.

Verification (bench memory model: 64 words, initialised to 0xEEEEEEEE, written on rising edge)
REQ-031 After reset, LW addr 0x0 -> mem_read for 1 cycle; resp_valid at accept+2 with resp_rdata=0xEEEEEEEE and resp_fault=0.
REQ-032 SW addr 0x8 data 0x80FF7F01, then:
- LB 0x9 -> 0x0000007F
- LB 0xA -> 0xFFFFFFFF
- LBU 0xA -> 0x000000FF
- LH 0xA -> 0xFFFF80FF
REQ-033 SB addr 0x5 data 0x000000AB -> mem_read then mem_write on word 1; word 1 becomes 0xEEEEABEE; resp_valid at accept+3.
REQ-034 LW addr 0x6 -> resp_fault=1 at accept+1 with no mem_read. SW addr 0x100 -> fault with no mem_write. Load with funct3 011 -> fault.
REQ-035 SH addr 0x12 accepted, reset pulsed low during READ -> no mem_write, no resp_valid, req_ready=1 after release, word 4 unchanged at 0xEEEEEEEE.
REQ-036 Back-to-back requests with req_valid held high: the second request is accepted only in the cycle after the first resp_valid, and both complete with correct data.
